// File: rtl/cla_multicycle_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract sequencer built on one 4-bit CLA slice.
// The operation runs one nibble per cycle, LSB nibble first. The carry between
// nibbles is held in a register, and valid/ready handshakes sit on both sides.

// 4-bit carry-lookahead slice.
module adder_4bit_cla (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[3:0];
    assign o_cout = w_c[4];
endmodule

// State table:
//   S_IDLE | waiting for an operand; in_ready=1
//   S_RUN  | one nibble per cycle through the slice
//   S_DONE | result held; waiting for out_ready
module cla_multicycle_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("cla_multicycle_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_last;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_s_sum;
    logic             w_s_cout;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_nib  = r_opa[{r_idx, 2'b00} +: 4];
    assign w_b_nib  = r_opb[{r_idx, 2'b00} +: 4];

    adder_4bit_cla u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_s_sum),
        .o_cout (w_s_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_next_state = S_RUN;
            S_RUN:   if (w_last)    w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand capture, per-nibble accumulation and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa       <= '0;
            r_opb       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_s_sum;
                    r_carry <= w_s_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout      <= w_s_cout;
                        r_ovf       <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                                       (w_s_sum[3] != r_opa[WIDTH-1]);
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_cla_multicycle_adder_ctrl.sv
// Directed bench for cla_multicycle_adder_ctrl at WIDTH=16.
module tb_cla_multicycle_adder_ctrl;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    cla_multicycle_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from IDLE: accept, count latency, check result, take it.
    task automatic run_op(input string tag,
                          input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                          input logic tsub, input logic [15:0] esum, input logic ecout,
                          input logic eovf);
        int cnt;
        in_valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_inrdy_run"}, 32'(in_ready), 32'd0);
        cnt = 0;
        while (cnt < 20 && !out_valid) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "_latency"}, 32'(cnt), 32'd4);
        chk({tag, "_sum"}, 32'(sum), 32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, 32'(out_valid), 32'd0);
        chk({tag, "_inrdy_idle"}, 32'(in_ready), 32'd1);
    endtask

    logic [15:0] q_a    [3] = '{16'h1111, 16'hFFFF, 16'h0003};
    logic [15:0] q_b    [3] = '{16'h2222, 16'hFFFF, 16'h0003};
    logic        q_sub  [3] = '{1'b0, 1'b0, 1'b1};
    logic [15:0] q_sum  [3] = '{16'h3333, 16'hFFFE, 16'h0000};
    logic        q_cout [3] = '{1'b0, 1'b1, 1'b1};
    int          acc_cyc[3];

    initial begin
        int cnt;
        int acc_cnt;
        int res_cnt;
        int cyc;
        logic pre_ready;
        logic [15:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add",    16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("ovfadd", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub1",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub2",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure in DONE with new operands offered.
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555;
        cnt = 0;
        while (cnt < 20 && !out_valid) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("bp_latency", 32'(cnt), 32'd4);
        held = 16'h1010;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sum", 32'(sum), 32'(held));
            chk("bp_flags", {29'd0, out_valid, cout, ovf}, 32'd4);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        chk("bp_release_idle", {30'd0, in_ready, out_valid}, 32'd2);
        run_op("bp_next", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // Asynchronous reset after two RUN cycles.
        in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_result", 32'(out_valid), 32'd0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        in_valid = 1'b1; a = q_a[0]; b = q_b[0]; sub = q_sub[0]; cin = 1'b0;
        acc_cnt = 0; res_cnt = 0; cyc = 0;
        while (res_cnt < 3 && cyc < 60) begin
            pre_ready = in_ready;
            @(posedge clk); #1;
            cyc++;
            if (pre_ready && acc_cnt < 3) begin
                acc_cyc[acc_cnt] = cyc;
                acc_cnt++;
                if (acc_cnt < 3) begin
                    a = q_a[acc_cnt]; b = q_b[acc_cnt]; sub = q_sub[acc_cnt];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                chk("b2b_sum", 32'(sum), 32'(q_sum[res_cnt]));
                chk("b2b_cout", 32'(cout), 32'(q_cout[res_cnt]));
                chk("b2b_ovf", 32'(ovf), 32'd0);
                res_cnt++;
            end
        end
        chk("b2b_results", 32'(res_cnt), 32'd3);
        chk("b2b_accepts", 32'(acc_cnt), 32'd3);
        if (acc_cnt == 3) begin
            chk("b2b_ii_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
            chk("b2b_ii_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
        end
        out_ready = 1'b0; in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
